// File: rtl/candy_seq_if.sv
// Sequencer-side handshakes for the candy core: instruction memory, decoder,
// execute unit, data memory and register-file write strobe.
interface candy_seq_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            ir_load;
  logic            id_enable;
  logic            ex_start;
  logic            ex_done;
  logic            need_mem;
  logic            need_wb;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            dmem_req;
  logic            dmem_ack;
  logic            wb_en;

  modport master (
    output imem_req, imem_addr, ir_load, id_enable, ex_start, dmem_req, wb_en,
    input  imem_ack, ex_done, need_mem, need_wb, branch_taken, branch_target, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, ir_load, id_enable, ex_start, dmem_req, wb_en,
    output imem_ack, ex_done, need_mem, need_wb, branch_taken, branch_target, dmem_ack
  );
endinterface

// File: rtl/candy_seq.sv
// Multi-cycle instruction sequencer: owns the PC and walks each instruction
// through FETCH, DECODE, EXEC, MEM, WB and PCUPD with a per-wait abort timer.
//
// state  | meaning
// IDLE   | stopped, waiting for start
// FETCH  | instruction fetch, waiting for imem_ack
// DECODE | one-cycle decode strobe
// EXEC   | execute started, waiting for ex_done
// MEM    | data access, waiting for dmem_ack
// WB     | one-cycle register write strobe
// PCUPD  | retire, advance or redirect the PC
module candy_seq #(
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_halt_req,
  candy_seq_if.master      bus,
  output logic             o_retire,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [TO_W-1:0]   r_wait;
  logic [TO_W-1:0]   w_wait_inc;
  logic              r_ex_first;
  logic              r_halt_pend;
  logic              r_timeout_err;
  logic              r_br_taken;
  logic [PC_W-1:0]   r_br_target;
  logic              r_need_wb;
  logic              w_waiting;
  logic              w_wait_ack;
  logic              w_to_hit;

  assign w_wait_inc = r_wait + 1'b1;

  always_comb begin
    w_next     = r_state;
    w_waiting  = 1'b0;
    w_wait_ack = 1'b0;
    w_to_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_waiting  = 1'b1;
        w_wait_ack = bus.imem_ack;
        if (bus.imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_waiting  = 1'b1;
        w_wait_ack = bus.ex_done;
        if (bus.ex_done) begin
          if (bus.need_mem)     w_next = S_MEM;
          else if (bus.need_wb) w_next = S_WB;
          else                  w_next = S_PCUPD;
        end
      end
      S_MEM: begin
        w_waiting  = 1'b1;
        w_wait_ack = bus.dmem_ack;
        if (bus.dmem_ack) w_next = r_need_wb ? S_WB : S_PCUPD;
      end
      S_WB: begin
        w_next = S_PCUPD;
      end
      S_PCUPD: begin
        w_next = (r_halt_pend || i_halt_req) ? S_IDLE : S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // An ack in the same cycle the limit is reached wins over the abort.
    if (w_waiting && !w_wait_ack && (w_wait_inc == TO_LIM)) begin
      w_to_hit = 1'b1;
      w_next   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RST;
      r_wait        <= '0;
      r_ex_first    <= 1'b0;
      r_halt_pend   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_br_taken    <= 1'b0;
      r_br_target   <= '0;
      r_need_wb     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state)
        r_wait <= '0;
      else if (w_waiting && !w_wait_ack)
        r_wait <= w_wait_inc;

      // EXEC is only ever entered from DECODE
      r_ex_first <= (r_state == S_DECODE);

      if (r_state == S_EXEC && bus.ex_done) begin
        r_br_taken  <= bus.branch_taken;
        r_br_target <= bus.branch_target;
        r_need_wb   <= bus.need_wb;
      end

      if (r_state == S_IDLE && i_start)
        r_timeout_err <= 1'b0;
      else if (w_to_hit)
        r_timeout_err <= 1'b1;

      if (r_state == S_PCUPD || w_to_hit)
        r_halt_pend <= 1'b0;
      else if (r_state != S_IDLE && i_halt_req)
        r_halt_pend <= 1'b1;

      if (r_state == S_PCUPD)
        r_pc <= r_br_taken ? r_br_target : r_pc + 1'b1;
    end
  end

  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.imem_addr = r_pc;
  assign bus.ir_load   = (r_state == S_FETCH) & bus.imem_ack;
  assign bus.id_enable = (r_state == S_DECODE);
  assign bus.ex_start  = (r_state == S_EXEC) & r_ex_first;
  assign bus.dmem_req  = (r_state == S_MEM);
  assign bus.wb_en     = (r_state == S_WB);

  assign o_retire      = (r_state == S_PCUPD);
  assign o_pc          = r_pc;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_candy_seq.sv
// Directed bench for candy_seq: scripted handshake responder plus a retire
// scoreboard of expected pc / write-back / latency per instruction.
module tb_candy_seq;
  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            halt_req = 1'b0;
  logic            retire;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            timeout_err;
  logic [2:0]      state;

  logic            imem_ack_v = 1'b0;
  logic            ex_done_v = 1'b0;
  logic            dmem_ack_v = 1'b0;
  logic            need_mem_v = 1'b0;
  logic            need_wb_v = 1'b0;
  logic            br_taken_v = 1'b0;
  logic [PC_W-1:0] br_target_v = '0;
  logic            dmem_force = 1'b0;

  int imem_dly = 0;
  int ex_dly = 0;
  int dmem_dly = 0;
  int icnt = 0;
  int ecnt = 0;
  int dcnt = 0;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            wb;
    int              lat;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0] prev_state = 3'd0;
  int         lat = 0;
  logic       wb_seen = 1'b0;
  int         seq_exp [6] = '{1, 2, 3, 5, 6, 1};

  always #5 clk = ~clk;

  candy_seq_if #(.PC_W(PC_W)) sif ();

  assign sif.imem_ack      = imem_ack_v;
  assign sif.ex_done       = ex_done_v;
  assign sif.dmem_ack      = dmem_ack_v;
  assign sif.need_mem      = need_mem_v;
  assign sif.need_wb       = need_wb_v;
  assign sif.branch_taken  = br_taken_v;
  assign sif.branch_target = br_target_v;

  candy_seq #(.PC_W(PC_W), .RESET_PC(0), .TIMEOUT(255), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_halt_req   (halt_req),
    .bus          (sif.master),
    .o_retire     (retire),
    .o_pc         (pc),
    .o_busy       (busy),
    .o_timeout_err(timeout_err),
    .o_state      (state)
  );

  // Responder: ack on the N-th cycle of a request (N = delay, -1 = never).
  always @(negedge clk) begin
    if (sif.imem_req) begin
      imem_ack_v <= (imem_dly >= 0 && icnt >= imem_dly);
      icnt       <= icnt + 1;
    end else begin
      imem_ack_v <= 1'b0;
      icnt       <= 0;
    end
    if (state == 3'd3) begin
      ex_done_v <= (ex_dly >= 0 && ecnt >= ex_dly);
      ecnt      <= ecnt + 1;
    end else begin
      ex_done_v <= 1'b0;
      ecnt      <= 0;
    end
    if (sif.dmem_req) begin
      dmem_ack_v <= (dmem_dly >= 0 && dcnt >= dmem_dly) || dmem_force;
      dcnt       <= dcnt + 1;
    end else begin
      dmem_ack_v <= dmem_force;
      dcnt       <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] p, input logic wb, input int l);
    exp_t e;
    e.pc  = p;
    e.wb  = wb;
    e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    if (state == 3'd1 && prev_state != 3'd1) lat = 1;
    else lat++;
    if (sif.wb_en) wb_seen = 1'b1;
    if (retire) begin
      if (exp_q.size() == 0) begin
        chk("retire_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("retire_pc", 32'(pc), 32'(e.pc));
        chk("retire_wb", 32'(wb_seen), 32'(e.wb));
        chk("retire_latency", lat, e.lat);
      end
      wb_seen = 1'b0;
    end
    prev_state = state;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    observe();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (state == 3'd0) done = 1'b1;
      else tick();
    end
    chk("wait_idle", 32'(done), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (state == s) done = 1'b1;
      else tick();
    end
    chk("wait_state", 32'(done), 32'd1);
  endtask

  // Start, then raise halt_req once the last requested instruction is under way.
  task automatic run_n(input int n, input int budget);
    int r;
    bit done;
    r = 0;
    done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (retire) r++;
      if (state == 3'd0) done = 1'b1;
      else begin
        halt_req = (r == n - 1 && state != 3'd6);
        tick();
      end
    end
    halt_req = 1'b0;
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    int dreq;
    int wbc;
    int retc;
    int fc;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_imem_req", 32'(sif.imem_req), 32'd0);
    chk("rst_dmem_req", 32'(sif.dmem_req), 32'd0);
    chk("rst_wb_en", 32'(sif.wb_en), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_id_enable", 32'(sif.id_enable), 32'd0);
    chk("rst_ex_start", 32'(sif.ex_start), 32'd0);
    rst = 1'b0;
    tick();

    // Write-back only, immediate acks: 5-cycle instructions
    need_wb_v = 1'b1;
    push(16'h0000, 1'b1, 5);
    push(16'h0001, 1'b1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("seq_state", 32'(state), 32'(seq_exp[i]));
      chk("seq_id_enable", 32'(sif.id_enable), 32'(seq_exp[i] == 2));
      chk("seq_ex_start", 32'(sif.ex_start), 32'(seq_exp[i] == 3));
      chk("seq_wb_en", 32'(sif.wb_en), 32'(seq_exp[i] == 5));
      chk("seq_retire", 32'(retire), 32'(seq_exp[i] == 6));
      chk("seq_busy", 32'(busy), 32'd1);
      if (i < 5) tick();
    end
    chk("pc_after_first", 32'(pc), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_idle(50);
    chk("t1_pc", 32'(pc), 32'd2);
    chk("t1_busy", 32'(busy), 32'd0);

    // MEM + WB with dmem_ack on the 4th request cycle
    need_mem_v = 1'b1;
    dmem_dly = 3;
    push(16'h0002, 1'b1, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    dreq = 0;
    wbc = 0;
    for (int c = 0; c < 50 && state != 3'd0; c++) begin
      if (sif.dmem_req) dreq++;
      if (sif.wb_en) wbc++;
      tick();
    end
    chk("t2_dmem_req_cycles", dreq, 4);
    chk("t2_wb_pulses", wbc, 1);
    chk("t2_pc", 32'(pc), 32'd3);

    // Plain instructions up to pc 7, then a taken branch
    need_mem_v = 1'b0;
    need_wb_v = 1'b0;
    dmem_dly = 0;
    for (int k = 3; k < 7; k++) push(16'(k), 1'b0, 4);
    run_n(4, 100);
    chk("t3_pc7", 32'(pc), 32'h7);
    br_taken_v = 1'b1;
    br_target_v = 16'h0040;
    push(16'h0007, 1'b0, 4);
    run_n(1, 50);
    chk("branch_pc", 32'(pc), 32'h40);
    br_taken_v = 1'b0;
    push(16'h0040, 1'b0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("branch_imem_addr", 32'(sif.imem_addr), 32'h40);
    chk("branch_imem_req", 32'(sif.imem_req), 32'd1);
    chk("branch_ir_load", 32'(sif.ir_load), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_idle(50);
    chk("branch_next_pc", 32'(pc), 32'h41);

    // PC wrap from 0xFFFF
    br_taken_v = 1'b1;
    br_target_v = 16'hFFFF;
    push(16'h0041, 1'b0, 4);
    run_n(1, 50);
    chk("pc_ffff", 32'(pc), 32'hFFFF);
    br_taken_v = 1'b0;
    push(16'hFFFF, 1'b0, 4);
    run_n(1, 50);
    chk("pc_wrap", 32'(pc), 32'h0);

    // Halt request in the first EXEC cycle; instruction still completes
    need_wb_v = 1'b1;
    ex_dly = 3;
    push(16'h0000, 1'b1, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd3, 10);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wbc = 0;
    retc = 0;
    for (int c = 0; c < 50 && state != 3'd0; c++) begin
      if (sif.wb_en) wbc++;
      if (retire) retc++;
      tick();
    end
    chk("halt_wb", wbc, 1);
    chk("halt_retire", retc, 1);
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc), 32'd1);
    ex_dly = 0;
    push(16'h0001, 1'b1, 5);
    run_n(1, 50);
    chk("resume_pc", 32'(pc), 32'd2);

    // Fetch timeout
    imem_dly = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_ir_load", 32'(sif.ir_load), 32'd0);
    fc = 0;
    for (int c = 0; c < 400 && state != 3'd0; c++) begin
      if (state == 3'd1) fc++;
      tick();
    end
    chk("to_fetch_cycles", fc, 255);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_state", 32'(state), 32'd0);
    chk("to_pc", 32'(pc), 32'd2);
    imem_dly = 0;
    push(16'h0002, 1'b1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_cleared", 32'(timeout_err), 32'd0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_idle(50);
    chk("to_resume_pc", 32'(pc), 32'd3);

    // Ack on the very cycle the limit is reached: no abort
    imem_dly = 254;
    need_wb_v = 1'b0;
    push(16'h0003, 1'b0, 258);
    run_n(1, 400);
    chk("edge_no_err", 32'(timeout_err), 32'd0);
    chk("edge_pc", 32'(pc), 32'd4);

    // Reset while waiting in MEM; late ack ignored
    imem_dly = 0;
    need_mem_v = 1'b1;
    dmem_dly = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(3'd4, 10);
    chk("mem_dmem_req", 32'(sif.dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_dmem_req", 32'(sif.dmem_req), 32'd0);
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_pc", 32'(pc), 32'd0);
    rst = 1'b0;
    dmem_force = 1'b1;
    tick();
    dmem_force = 1'b0;
    tick();
    tick();
    chk("late_ack_state", 32'(state), 32'd0);
    chk("late_ack_pc", 32'(pc), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
